// File: rtl/rep_seq_checker_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rep_seq_pkg
//
// Shared types and helpers for the repetition-sequence checker:
//   mode_e     - operator selected by the mode input:
//                [*]  consecutive, [->] goto, [=] non-consecutive.
//   state_e    - checker FSM states. Each active state maps one-to-one onto
//                the operator being evaluated.
//   cfg_legal  - decides whether a (mode, min, max) triple describes a
//                checkable property.
// ---------------------------------------------------------------------------
package rep_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CONSEC  = 2'd0,
    MODE_GOTO    = 2'd1,
    MODE_NONCONS = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONSEC = 2'd1,
    S_GOTO   = 2'd2,
    S_NCONS  = 2'd3
  } state_e;

  // The bounds are passed as 32-bit values so a single helper serves every
  // CNT_W. Callers zero-extend their bound registers.
  // A goto with m=0 has no first match to wait for, so it is rejected
  // together with the reserved encoding and an inverted range.
  function automatic logic cfg_legal(input mode_e       mode,
                                     input int unsigned min_v,
                                     input int unsigned max_v);
    logic ok;
    ok = 1'b1;
    if (mode == MODE_RSVD) begin
      ok = 1'b0;
    end
    if (min_v > max_v) begin
      ok = 1'b0;
    end
    if ((mode == MODE_GOTO) && (min_v == 0)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/rep_seq_checker_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rep_seq_checker_if
//
// Bundles the sampled A/B pair, the property configuration and every
// verdict/statistics output of rep_seq_checker.
//
// Signal protocol: there is no valid/ready pair. en, a, b, mode, min_rep and
// max_rep are sampled on every rising clk edge. mode, min_rep and max_rep
// matter only on the cycle in which a trigger (en=1, a=1) is accepted in
// idle. All outputs are registered. pass, fail, cfg_err and drop are
// single-cycle pulses. busy stays high for the whole attempt.
//
// Modports:
//   master - the side that drives the samples and configuration and
//            observes the results (the bench or the surrounding logic).
//   slave  - the checker itself.
// ---------------------------------------------------------------------------
interface rep_seq_checker_if #(
  parameter int CNT_W  = 4,
  parameter int STAT_W = 16
);

  logic              en;
  logic              a;
  logic              b;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  min_rep;
  logic [CNT_W-1:0]  max_rep;

  logic              busy;
  logic              pass;
  logic              fail;
  logic              cfg_err;
  logic              drop;
  logic [CNT_W-1:0]  occ;
  logic [STAT_W-1:0] pass_cnt;
  logic [STAT_W-1:0] fail_cnt;
  logic [1:0]        dbg_state;  // FSM state, encoded as rep_seq_pkg::state_e

  modport master (
    output en, a, b, mode, min_rep, max_rep,
    input  busy, pass, fail, cfg_err, drop, occ, pass_cnt, fail_cnt, dbg_state
  );

  modport slave (
    input  en, a, b, mode, min_rep, max_rep,
    output busy, pass, fail, cfg_err, drop, occ, pass_cnt, fail_cnt, dbg_state
  );

endinterface

// File: rtl/rep_seq_checker_sat_counter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating event counter. It counts one per cycle while inc is high and
// then holds at all-ones, so a long run never wraps back to a small value.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset (clears count)
//   inc    in   count-enable pulse
//   count  out  current count, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rep_seq_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rep_seq_checker
//
// Synthesizable evaluator for the properties
//   a ##1 b[*m:n]   (consecutive)
//   a ##1 b[->m:n]  (goto, first match at m)
//   a ##1 b[=m:n]   (non-consecutive, judged over a fixed window)
// It produces registered pass/fail pulses and saturating verdict counters.
// Only one attempt runs at a time. A trigger seen while busy is reported on
// drop and is otherwise ignored.
//
// Parameters:
//   CNT_W   width of the repetition bounds and of occ
//   WINDOW  evaluation window in cycles for goto and non-consecutive (>= 1)
//   STAT_W  width of pass_cnt / fail_cnt
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset
//   bus  slave modport of rep_seq_checker_if:
//        in  en, a, b, mode[1:0], min_rep, max_rep
//        out busy, pass, fail, cfg_err, drop, occ, pass_cnt, fail_cnt,
//            dbg_state
// ---------------------------------------------------------------------------
module rep_seq_checker
  import rep_seq_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int WINDOW = 8,
  parameter int STAT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  rep_seq_checker_if.slave    bus
);

  localparam int              WC_W    = $clog2(WINDOW + 1);
  localparam logic [WC_W-1:0] WLAST   = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] OCC_MAX = '1;

  state_e            state;
  logic [CNT_W-1:0]  lat_min;
  logic [CNT_W-1:0]  lat_max;
  logic [CNT_W-1:0]  occ;
  logic [WC_W-1:0]   wcnt;
  logic              pass_q;
  logic              fail_q;
  logic              cfg_err_q;
  logic              drop_q;

  logic              busy;
  logic              trig_legal;
  logic [CNT_W-1:0]  occ_inc;
  logic [CNT_W-1:0]  occ_sat;

  assign busy       = (state != S_IDLE);
  assign trig_legal = cfg_legal(mode_e'(bus.mode),
                                32'(bus.min_rep), 32'(bus.max_rep));
  assign occ_inc    = occ + 1'b1;
  // In non-consecutive mode the count includes the current b and sticks at
  // all-ones. The window-end verdict uses this value, so a b on the last
  // window cycle is still counted.
  assign occ_sat    = (bus.b && (occ != OCC_MAX)) ? occ_inc : occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      lat_min   <= '0;
      lat_max   <= '0;
      occ       <= '0;
      wcnt      <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      // Any trigger seen while busy is reported, including one on the
      // deciding cycle. It never starts an attempt.
      drop_q    <= busy && bus.a;

      if (busy && !bus.en) begin
        // Disable aborts silently: no verdict, counters untouched.
        state <= S_IDLE;
        occ   <= '0;
        wcnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.en && bus.a) begin
              lat_min <= bus.min_rep;
              lat_max <= bus.max_rep;
              occ     <= '0;
              wcnt    <= '0;
              if (!trig_legal) begin
                cfg_err_q <= 1'b1;
                fail_q    <= 1'b1;
              end else begin
                case (mode_e'(bus.mode))
                  MODE_CONSEC:  state <= S_CONSEC;
                  MODE_GOTO:    state <= S_GOTO;
                  MODE_NONCONS: state <= S_NCONS;
                  default:      state <= S_IDLE;
                endcase
              end
            end
          end

          S_CONSEC: begin
            if (bus.b) begin
              // occ never exceeds lat_max here, so one more b means overrun.
              // occ is left at lat_max instead of showing the rejected count.
              if (occ >= lat_max) begin
                fail_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                occ <= occ_inc;
              end
            end else begin
              if ((occ >= lat_min) && (occ <= lat_max)) begin
                pass_q <= 1'b1;
              end else begin
                fail_q <= 1'b1;
              end
              state <= S_IDLE;
            end
          end

          S_GOTO: begin
            wcnt <= wcnt + 1'b1;
            if (bus.b) begin
              occ <= occ_inc;
            end
            // A first match on the last window cycle still counts as a pass.
            if (bus.b && (occ_inc == lat_min)) begin
              pass_q <= 1'b1;
              state  <= S_IDLE;
            end else if (wcnt == WLAST) begin
              fail_q <= 1'b1;
              state  <= S_IDLE;
            end
          end

          S_NCONS: begin
            wcnt <= wcnt + 1'b1;
            occ  <= occ_sat;
            if (wcnt == WLAST) begin
              if ((occ_sat >= lat_min) && (occ_sat <= lat_max)) begin
                pass_q <= 1'b1;
              end else begin
                fail_q <= 1'b1;
              end
              state <= S_IDLE;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // The statistics count the registered pulses. Each counter therefore
  // advances on the edge that ends its pulse cycle.
  sat_counter #(.WIDTH(STAT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pass_q),
    .count (bus.pass_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fail_q),
    .count (bus.fail_cnt)
  );

  assign bus.busy      = busy;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.drop      = drop_q;
  assign bus.occ       = occ;
  assign bus.dbg_state = state;

endmodule
